// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: packs symbolic instructions into 32-bit machine words
// and writes them to consecutive imem word addresses starting at 0.
module legv8_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | waiting for an instruction handshake
  // WR    | strobing the registered word into imem
  // DONE  | last instruction written, sticky until clear/reset
  // ERR   | illegal immediate or overflow, sticky until clear/reset
  typedef enum logic [1:0] {S_IDLE, S_WR, S_DONE, S_ERR} state_t;

  localparam logic [2:0] K_LDUR = 3'd0;
  localparam logic [2:0] K_STUR = 3'd1;
  localparam logic [2:0] K_CBZ  = 3'd2;
  localparam logic [2:0] K_ADD  = 3'd3;
  localparam logic [2:0] K_ADDI = 3'd4;
  localparam logic [2:0] K_SUB  = 3'd5;
  localparam logic [2:0] K_AND  = 3'd6;
  localparam logic [2:0] K_ORR  = 3'd7;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(2**ADDR_W);

  state_t      state, state_nxt;
  logic        last_q;
  logic [31:0] word;
  logic        legal;
  logic        accept;
  logic        go_wr;

  always_comb begin
    word  = 32'h0;
    legal = 1'b1;
    case (in_kind)
      K_LDUR: begin
        word  = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rd};
        legal = (&in_imm[18:8]) || !(|in_imm[18:8]);
      end
      K_STUR: begin
        word  = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rd};
        legal = (&in_imm[18:8]) || !(|in_imm[18:8]);
      end
      K_CBZ:  word = {8'b10110100, in_imm, in_rd};
      K_ADD:  word = {11'b10001011000, in_rm, 6'b000000, in_rn, in_rd};
      K_ADDI: begin
        word  = {10'b1001000100, in_imm[11:0], in_rn, in_rd};
        legal = !(|in_imm[18:12]);
      end
      K_SUB:  word = {11'b11001011000, in_rm, 6'b000000, in_rn, in_rd};
      K_AND:  word = {11'b10001010000, in_rm, 6'b000000, in_rn, in_rd};
      K_ORR:  word = {11'b10101010000, in_rm, 6'b000000, in_rn, in_rd};
      default: begin
        word  = 32'h0;
        legal = 1'b0;
      end
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign imem_we   = (state == S_WR);
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  assign imem_addr = count[ADDR_W-1:0];

  // clear wins over a simultaneous handshake
  assign accept = in_valid && in_ready && !clear;
  assign go_wr  = accept && legal && (count != FULL);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = go_wr ? S_WR : S_ERR;
      S_WR:   state_nxt = last_q ? S_DONE : S_IDLE;
      S_DONE: state_nxt = S_DONE;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      count      <= '0;
      imem_wdata <= 32'h0;
      last_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clear)
        count <= '0;
      else if (state == S_WR)
        count <= count + 1'b1;
      if (go_wr) begin
        imem_wdata <= word;
        last_q     <= in_last;
      end
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Scoreboard bench for legv8_instr_encoder: expected writes are queued at the
// handshake and popped by a write monitor; a second, 4-word instance covers overflow.
module tb_legv8_instr_encoder;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_last;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd, in_rn, in_rm;
  logic [18:0] in_imm;

  logic        in_ready, imem_we, done, err;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0]  count;

  logic        s_ready, s_we, s_done, s_err;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;
  logic [2:0]  s_count;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  logic [37:0] sb[$];
  logic [1:0]  s_addrs[$];

  always #5 clk = ~clk;

  legv8_instr_encoder #(.ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err(err)
  );

  legv8_instr_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(s_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .in_last(in_last), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .count(s_count), .done(s_done), .err(s_err)
  );

  function automatic logic [31:0] model(input logic [2:0] k, input logic [4:0] rd, rn, rm,
                                        input logic [18:0] imm);
    logic [31:0] rt;
    rt = 32'(rn) << 5 | 32'(rd);
    case (k)
      3'd0: return 32'h7C2 << 21 | 32'(imm[8:0]) << 12 | rt;
      3'd1: return 32'h7C0 << 21 | 32'(imm[8:0]) << 12 | rt;
      3'd2: return 32'hB4 << 24 | 32'(imm) << 5 | 32'(rd);
      3'd3: return 32'h458 << 21 | 32'(rm) << 16 | rt;
      3'd4: return 32'h244 << 22 | 32'(imm[11:0]) << 10 | rt;
      3'd5: return 32'h658 << 21 | 32'(rm) << 16 | rt;
      3'd6: return 32'h450 << 21 | 32'(rm) << 16 | rt;
      default: return 32'h550 << 21 | 32'(rm) << 16 | rt;
    endcase
  endfunction

  always @(negedge clk) begin
    logic [37:0] e;
    if (imem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got addr=%0d data=%h exp no write", imem_addr, imem_wdata);
      end else begin
        e = sb.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write got addr=%0d data=%h exp addr=%0d data=%h",
                   imem_addr, imem_wdata, e[37:32], e[31:0]);
        end
      end
    end
    if (s_we === 1'b1) s_addrs.push_back(s_addr);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0;
    cycle();
    reset = 1'b0;
    exp_count = 0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    exp_count = 0;
  endtask

  // Handshake one instruction, scramble the fields during WR, then let WR finish.
  task automatic send(input logic [2:0] k, input logic [4:0] rd, rn, rm, input logic [18:0] imm,
                      input logic last, input bit exp_wr, input logic [31:0] w);
    int n = 0;
    in_kind = k; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_last = last;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin cycle(); n++; end
    if (in_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL handshake_timeout got in_ready=%b exp 1", in_ready);
    end
    if (exp_wr) begin
      sb.push_back({6'(exp_count), w});
      exp_count++;
    end
    cycle();
    in_valid = 1'b0;
    in_kind = 3'(~k); in_rd = ~rd; in_rn = ~rn; in_rm = ~rm; in_imm = ~imm; in_last = ~last;
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done_err", {done, err}, 32'd0);
  endtask

  task automatic test_basic();
    send(3'd0, 5'd1, 5'd0, 5'd0, 19'd8, 1'b0, 1'b1, 32'hF8408001);
    chk("ldur_count", 32'(count), 32'd1);
    chk("ldur_in_ready", 32'(in_ready), 32'd1);
    send(3'd3, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0, 1'b1, 32'h8B020023);
    send(3'd2, 5'd5, 5'd0, 5'd0, 19'h7FFFE, 1'b1, 1'b1, 32'hB4FFFFC5);
    chk("cbz_done", 32'(done), 32'd1);
    chk("cbz_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_kind = 3'd3; in_last = 1'b0;
    repeat (3) cycle();
    in_valid = 1'b0;
    chk("done_ignores_valid_count", 32'(count), 32'd3);
    chk("done_sticky", 32'(done), 32'd1);
    do_clear();
    chk("clear_done", {done, err, in_ready}, 32'd1);
  endtask

  task automatic test_encodings();
    logic [4:0] rd, rn, rm;
    for (int i = 0; i < 8; i++) begin
      rd = 5'($urandom_range(0, 31)); rn = 5'($urandom_range(0, 31)); rm = 5'($urandom_range(0, 31));
      send(3'(i), rd, rn, rm, 19'h7FF00, 1'b0, (i != 4), model(3'(i), rd, rn, rm, 19'h7FF00));
      if (i == 4) do_clear();
    end
    send(3'd4, 5'd7, 5'd9, 5'd0, 19'h00FFF, 1'b0, 1'b1, 32'h913FFD27);
    send(3'd1, 5'd2, 5'd4, 5'd0, 19'h000FF, 1'b0, 1'b1, model(3'd1, 5'd2, 5'd4, 5'd0, 19'h000FF));
    chk("enc_count", 32'(count), 32'(exp_count));
    do_clear();
  endtask

  task automatic test_err();
    send(3'd5, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0, 1'b1, 32'hCB030041);
    send(3'd4, 5'd1, 5'd1, 5'd0, 19'h01000, 1'b0, 1'b0, 32'h0);
    chk("addi_err", 32'(err), 32'd1);
    chk("addi_err_count", 32'(count), 32'd1);
    chk("addi_err_ready", 32'(in_ready), 32'd0);
    do_clear();
    chk("clear_err", {err, in_ready}, 32'd1);
    chk("clear_count", 32'(count), 32'd0);
    send(3'd0, 5'd1, 5'd1, 5'd0, 19'h00100, 1'b0, 1'b0, 32'h0);
    chk("ldur_range_err", 32'(err), 32'd1);
    do_clear();
  endtask

  task automatic test_overflow();
    do_reset();
    s_addrs.delete();
    for (int i = 0; i < 4; i++)
      send(3'd7, 5'(i), 5'd1, 5'd2, 19'd0, 1'b0, 1'b1, model(3'd7, 5'(i), 5'd1, 5'd2, 19'd0));
    chk("ovf_nwrites", 32'(s_addrs.size()), 32'd4);
    for (int i = 0; i < 4 && i < s_addrs.size(); i++) chk("ovf_addr", 32'(s_addrs[i]), 32'(i));
    chk("ovf_count_full", 32'(s_count), 32'd4);
    send(3'd7, 5'd9, 5'd1, 5'd2, 19'd0, 1'b0, 1'b1, model(3'd7, 5'd9, 5'd1, 5'd2, 19'd0));
    chk("ovf_err", 32'(s_err), 32'd1);
    chk("ovf_no_write", 32'(s_addrs.size()), 32'd4);
    chk("ovf_count_held", 32'(s_count), 32'd4);
    do_reset();
  endtask

  task automatic test_reset_mid_wr();
    send(3'd3, 5'd1, 5'd1, 5'd1, 19'd0, 1'b0, 1'b1, model(3'd3, 5'd1, 5'd1, 5'd1, 19'd0));
    in_kind = 3'd6; in_rd = 5'd4; in_rn = 5'd5; in_rm = 5'd6; in_last = 1'b0; in_valid = 1'b1;
    sb.push_back({6'(exp_count), model(3'd6, 5'd4, 5'd5, 5'd6, 19'd0)});
    cycle();
    in_valid = 1'b0;
    chk("wr_strobe", 32'(imem_we), 32'd1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_count = 0;
    chk("rst_wr_we", 32'(imem_we), 32'd0);
    chk("rst_wr_count", 32'(count), 32'd0);
    chk("rst_wr_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic test_clear_priority();
    send(3'd3, 5'd2, 5'd2, 5'd2, 19'd0, 1'b0, 1'b1, model(3'd3, 5'd2, 5'd2, 5'd2, 19'd0));
    in_kind = 3'd3; in_valid = 1'b1; clear = 1'b1;
    cycle();
    in_valid = 1'b0; clear = 1'b0;
    exp_count = 0;
    chk("clr_pri_we", 32'(imem_we), 32'd0);
    chk("clr_pri_count", 32'(count), 32'd0);
    cycle();
    chk("clr_pri_ready", {imem_we, in_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_kind = 3'd0; in_rd = 5'd0; in_rn = 5'd0; in_rm = 5'd0; in_imm = 19'd0;
    cycle();
    test_reset();
    test_basic();
    test_encodings();
    test_err();
    test_overflow();
    test_reset_mid_wr();
    test_clear_priority();
    repeat (3) cycle();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
